// File: rtl/vga_timing_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_timing_gen : parametrised raster timing generator, zero-skew outputs |
// | rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [CW-1:0] H_MAX    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          h_wrap;

  assign p_tick = en && (div_cnt_q == DIV_LAST);

  // Decoded outputs are computed from the counter next-state so they land on the same edge as x/y.
  always_comb begin
    div_cnt_d     = div_cnt_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    h_wrap        = (h_cnt_q == H_MAX);
    if (en) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
    end
    if (p_tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + CW'(1);
      if (h_wrap) begin
        v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + CW'(1);
      end
      hsync_d       = ((h_cnt_d >= HS_START) && (h_cnt_d <= HS_END)) ? HS_POL : ~HS_POL;
      vsync_d       = ((v_cnt_d >= VS_START) && (v_cnt_d <= VS_END)) ? VS_POL : ~VS_POL;
      video_on_d    = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && (v_cnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= H_MAX;
      v_cnt_q       <= V_MAX;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign x           = h_cnt_q;
  assign y           = v_cnt_q;

endmodule
`default_nettype wire
